// File: rtl/switch_arbiter_if.sv
// -----------------------------------------------------------------------------
// switch_arbiter_if
//   Bundles the request/grant and switch-select signals between the two
//   requesters (CPU core, DMA engine) and the switch_arbiter.
//
//   Signals:
//     req        [1:0] req[i] high = requester i wants the switch
//     dst        [1:0] dst[i] = switch output targeted by requester i
//     gnt        [1:0] one-hot grant, 00 when the switch has no owner
//     in_select        switch input select (current or last owner index)
//     out_select       switch output select (latched dst of that owner)
//     sw_en            high only while an owner holds the switch
//
//   Modports:
//     master : requester side (drives req/dst, observes grant and selects)
//     slave  : arbiter side   (observes req/dst, drives grant and selects)
// -----------------------------------------------------------------------------
interface switch_arbiter_if;
  logic [1:0] req;
  logic [1:0] dst;
  logic [1:0] gnt;
  logic       in_select;
  logic       out_select;
  logic       sw_en;

  modport master (
    output req, dst,
    input  gnt, in_select, out_select, sw_en
  );

  modport slave (
    input  req, dst,
    output gnt, in_select, out_select, sw_en
  );
endinterface : switch_arbiter_if

// File: rtl/switch_arbiter.sv
// -----------------------------------------------------------------------------
// switch_arbiter
//   Sequencing controller for the shared 2-to-2 bus switch. Arbitrates two
//   requesters round-robin, drives the switch selects from registered grant
//   state and inserts a dead (TURN) cycle between owners so the switch's
//   tri-stated outputs never see two drivers.
//
//   Build option:
//     SWITCH_ARB_TIMEOUT_EN  when defined, an owner that has held the switch
//                            for HOLD_MAX cycles is forced off as soon as the
//                            other requester is waiting. When undefined the
//                            only release path is the owner dropping req.
//
//   Parameters:
//     HOLD_MAX   maximum grant length under contention (1..2^CNT_WIDTH-1)
//     CNT_WIDTH  hold counter width
//
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      switch_arbiter_if.slave (req, dst in; gnt, selects, sw_en out)
// -----------------------------------------------------------------------------
module switch_arbiter #(
  parameter int HOLD_MAX  = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  switch_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  // Reject an out-of-range hold limit when the design is elaborated.
  if (HOLD_MAX < 1 || HOLD_MAX > (2 ** CNT_WIDTH) - 1) begin : g_bad_hold_max
    $error("switch_arbiter: HOLD_MAX out of range for CNT_WIDTH");
  end

  state_t     r_state,    w_state_nxt;
  logic [1:0] r_gnt,      w_gnt_nxt;
  logic       r_in_sel,   w_in_sel_nxt;
  logic       r_out_sel,  w_out_sel_nxt;
  logic       r_sw_en,    w_sw_en_nxt;
  logic       r_prio,     w_prio_nxt;   // requester that wins the next tie
  logic       w_win;                    // winner index while in IDLE

`ifdef SWITCH_ARB_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  localparam logic [CNT_WIDTH-1:0] HOLD_LIM = CNT_WIDTH'(HOLD_MAX);
`endif

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge value of the others; blocking here would create ordering bugs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_gnt     <= 2'b00;
      r_in_sel  <= 1'b0;
      r_out_sel <= 1'b0;
      r_sw_en   <= 1'b0;
      r_prio    <= 1'b0;
`ifdef SWITCH_ARB_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_in_sel  <= w_in_sel_nxt;
      r_out_sel <= w_out_sel_nxt;
      r_sw_en   <= w_sw_en_nxt;
      r_prio    <= w_prio_nxt;
`ifdef SWITCH_ARB_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first; any
    // path that skipped an assignment would otherwise infer a latch.
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_in_sel_nxt  = r_in_sel;
    w_out_sel_nxt = r_out_sel;
    w_sw_en_nxt   = r_sw_en;
    w_prio_nxt    = r_prio;
    w_win         = 1'b0;
`ifdef SWITCH_ARB_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
`endif

    unique case (r_state)
      IDLE: begin
        w_gnt_nxt   = 2'b00;
        w_sw_en_nxt = 1'b0;
        if (|bus.req) begin
          // A lone requester wins outright; a tie goes to the pointer.
          w_win         = (&bus.req) ? r_prio : bus.req[1];
          w_state_nxt   = OWN;
          w_gnt_nxt     = w_win ? 2'b10 : 2'b01;
          w_in_sel_nxt  = w_win;
          w_out_sel_nxt = bus.dst[w_win];
          w_sw_en_nxt   = 1'b1;
          w_prio_nxt    = ~w_win;
`ifdef SWITCH_ARB_TIMEOUT_EN
          w_cnt_nxt     = CNT_WIDTH'(1);
`endif
        end
      end

      OWN: begin
        // Selects stay frozen; r_in_sel is the owner index.
        if (!bus.req[r_in_sel]) begin
          w_state_nxt = TURN;
          w_gnt_nxt   = 2'b00;
          w_sw_en_nxt = 1'b0;
        end
`ifdef SWITCH_ARB_TIMEOUT_EN
        else if (r_cnt == HOLD_LIM && bus.req[~r_in_sel]) begin
          w_state_nxt = TURN;
          w_gnt_nxt   = 2'b00;
          w_sw_en_nxt = 1'b0;
        end else if (r_cnt != HOLD_LIM) begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
`endif
      end

      TURN: begin
        // Single dead cycle; selects keep the last owner's values.
        w_state_nxt = IDLE;
        w_gnt_nxt   = 2'b00;
        w_sw_en_nxt = 1'b0;
      end

      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 2'b00;
        w_sw_en_nxt = 1'b0;
      end
    endcase
  end

  assign bus.gnt        = r_gnt;
  assign bus.in_select  = r_in_sel;
  assign bus.out_select = r_out_sel;
  assign bus.sw_en      = r_sw_en;

endmodule : switch_arbiter

// File: tb/tb_switch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_switch_arbiter
//   Directed bench for switch_arbiter (HOLD_MAX=4, CNT_WIDTH=4). Inputs change
//   and outputs are sampled 1 time unit after each rising edge. Expected values
//   for the timeout scenarios follow SWITCH_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_switch_arbiter;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  switch_arbiter_if bus ();

  switch_arbiter #(
    .HOLD_MAX  (4),
    .CNT_WIDTH (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    bus.req = 2'b00;
    bus.dst = 2'b00;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  // {gnt, sw_en, in_select, out_select}
  function automatic logic [4:0] obs();
    return {bus.gnt, bus.sw_en, bus.in_select, bus.out_select};
  endfunction

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (obs() !== 5'b00_0_0_0) begin
      n_err++;
      $display("FAIL reset_state: got %b expected %b", obs(), 5'b00_0_0_0);
    end
  endtask

  task automatic test_basic_grant();
    apply_reset();
    bus.req = 2'b01;
    bus.dst = 2'b01;
    tick();
    n_cmp++;
    if (obs() !== 5'b01_1_0_1) begin
      n_err++;
      $display("FAIL basic_grant: got %b expected %b", obs(), 5'b01_1_0_1);
    end
    bus.req = 2'b00;
    tick();
    n_cmp++;
    if (obs() !== 5'b00_0_0_1) begin
      n_err++;
      $display("FAIL basic_release: got %b expected %b", obs(), 5'b00_0_0_1);
    end
    tick();
    n_cmp++;
    if (obs() !== 5'b00_0_0_1) begin
      n_err++;
      $display("FAIL basic_idle_hold: got %b expected %b", obs(), 5'b00_0_0_1);
    end
  endtask

  task automatic test_tie_round_robin();
    apply_reset();
    bus.req = 2'b11;
    bus.dst = 2'b10;
    tick();
    n_cmp++;
    if (obs() !== 5'b01_1_0_0) begin
      n_err++;
      $display("FAIL tie_first: got %b expected %b", obs(), 5'b01_1_0_0);
    end
    bus.req = 2'b10;              // owner 0 drops for one cycle
    tick();
    n_cmp++;
    if (bus.gnt !== 2'b00 || bus.sw_en !== 1'b0) begin
      n_err++;
      $display("FAIL rr_turn: got gnt=%b sw_en=%b expected gnt=00 sw_en=0",
               bus.gnt, bus.sw_en);
    end
    bus.req = 2'b11;
    tick();
    n_cmp++;
    if (bus.gnt !== 2'b00) begin
      n_err++;
      $display("FAIL rr_idle: got gnt=%b expected 00", bus.gnt);
    end
    tick();
    n_cmp++;
    if (obs() !== 5'b10_1_1_1) begin
      n_err++;
      $display("FAIL rr_second: got %b expected %b", obs(), 5'b10_1_1_1);
    end
    bus.req = 2'b01;              // owner 1 drops, 0 still waiting
    repeat (2) tick();
    n_cmp++;
    if (bus.gnt !== 2'b00) begin
      n_err++;
      $display("FAIL rr_dead_time: got gnt=%b expected 00", bus.gnt);
    end
    tick();
    n_cmp++;
    if (obs() !== 5'b01_1_0_0) begin
      n_err++;
      $display("FAIL rr_third: got %b expected %b", obs(), 5'b01_1_0_0);
    end
  endtask

  task automatic test_dst_latch();
    logic [4:0] exp;
    apply_reset();
    bus.req = 2'b10;
    bus.dst = 2'b00;
    tick();
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (obs() !== 5'b10_1_1_0) begin
        n_err++;
        $display("FAIL dst_latch[%0d]: got %b expected %b", i, obs(), 5'b10_1_1_0);
      end
      bus.dst[1] = ~bus.dst[1];
      tick();
    end
    bus.req = 2'b00;
    bus.dst = 2'b10;
    tick();
    n_cmp++;
    if (obs() !== 5'b00_0_1_0) begin
      n_err++;
      $display("FAIL dst_turn_hold: got %b expected %b", obs(), 5'b00_0_1_0);
    end
    bus.req = 2'b10;
    repeat (2) tick();
    exp = 5'b10_1_1_1;
    n_cmp++;
    if (obs() !== exp) begin
      n_err++;
      $display("FAIL dst_regrant: got %b expected %b", obs(), exp);
    end
  endtask

  task automatic test_hold_limit();
    logic [1:0] exp;
    apply_reset();
    bus.req = 2'b11;
    for (int t = 0; t < 120; t++) begin
      tick();
`ifdef SWITCH_ARB_TIMEOUT_EN
      // 4 cycles owner, 2 dead cycles, owners alternate 0,1,0,...
      if ((t % 6) >= 4)          exp = 2'b00;
      else if (((t / 6) % 2) == 0) exp = 2'b01;
      else                       exp = 2'b10;
`else
      exp = 2'b01;
`endif
      n_cmp++;
      if (bus.gnt !== exp || bus.sw_en !== (|exp)) begin
        n_err++;
        $display("FAIL hold_limit[%0d]: got gnt=%b sw_en=%b expected gnt=%b",
                 t, bus.gnt, bus.sw_en, exp);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp;
    apply_reset();
    bus.req = 2'b10;
    for (int t = 0; t < 20; t++) begin
      tick();
      n_cmp++;
      if (bus.gnt !== 2'b10) begin
        n_err++;
        $display("FAIL sat_hold[%0d]: got gnt=%b expected 10", t, bus.gnt);
      end
    end
    bus.req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      tick();
`ifdef SWITCH_ARB_TIMEOUT_EN
      exp = (t == 2) ? 2'b01 : 2'b00;
`else
      exp = 2'b10;
`endif
      n_cmp++;
      if (bus.gnt !== exp) begin
        n_err++;
        $display("FAIL sat_release[%0d]: got gnt=%b expected %b", t, bus.gnt, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.req = 2'b01;
    bus.dst = 2'b01;
    tick();                       // owner 0, pointer now favours 1
    bus.req = 2'b11;
    #2;
    reset_n = 1'b0;               // between edges
    #1;
    n_cmp++;
    if (obs() !== 5'b00_0_0_0) begin
      n_err++;
      $display("FAIL async_reset: got %b expected %b", obs(), 5'b00_0_0_0);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (obs() !== 5'b01_1_0_1) begin
      n_err++;
      $display("FAIL post_reset_tie: got %b expected %b", obs(), 5'b01_1_0_1);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    bus.req = 2'b00;
    bus.dst = 2'b00;
    test_reset();
    test_basic_grant();
    test_tie_round_robin();
    test_dst_latch();
    test_hold_limit();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_switch_arbiter
